// File: rtl/multi_channel_fifo_queue_if.sv
// Shared write/read handshake bundle for multi_channel_fifo_queue.
// master = producer/consumer side, slave = queue block.
interface multi_channel_fifo_queue_if #(
    parameter int CHANNEL_ID_WIDTH           = 2,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64
);
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in;
    logic [CHANNEL_ID_WIDTH-1:0]           request_channel_in;
    logic                                  request_valid_in;
    logic                                  issue_ack_out;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out;
    logic [CHANNEL_ID_WIDTH-1:0]           request_channel_out;
    logic                                  request_valid_out;
    logic                                  issue_ack_in;

    modport master (
        output request_in,
        output request_channel_in,
        output request_valid_in,
        output issue_ack_in,
        input  issue_ack_out,
        input  request_out,
        input  request_channel_out,
        input  request_valid_out
    );

    modport slave (
        input  request_in,
        input  request_channel_in,
        input  request_valid_in,
        input  issue_ack_in,
        output issue_ack_out,
        output request_out,
        output request_channel_out,
        output request_valid_out
    );
endinterface

// File: rtl/multi_channel_fifo_queue.sv
// N independent FIFO channels behind one write port and one round-robin read port.
// Optional MC_FIFO_OVERFLOW_DROP_EN: writes to a full channel are acked and dropped.
module multi_channel_fifo_queue #(
    parameter int NUM_CHANNELS               = 4,
    parameter int CHANNEL_ID_WIDTH           = 2,
    parameter int QUEUE_SIZE                 = 16,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = 4,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int ALMOST_FULL_THRESHOLD      = 12
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    multi_channel_fifo_queue_if.slave     bus,
    output logic [NUM_CHANNELS-1:0]       is_empty_out,
    output logic [NUM_CHANNELS-1:0]       is_full_out,
    output logic [NUM_CHANNELS-1:0]       is_almost_full_out,
    output logic [NUM_CHANNELS-1:0]       overflow_out
);
    localparam int CNT_W = QUEUE_PTR_WIDTH_IN_BITS + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESHOLD);

    typedef logic [QUEUE_PTR_WIDTH_IN_BITS-1:0]    ptr_t;
    typedef logic [CNT_W-1:0]                      cnt_t;
    typedef logic [CHANNEL_ID_WIDTH-1:0]           ch_t;
    typedef logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] data_t;
    typedef enum logic {IDLE, PRESENT} arb_state_e;

    data_t      mem_q    [NUM_CHANNELS][QUEUE_SIZE];
    ptr_t       wr_ptr_q [NUM_CHANNELS];
    ptr_t       wr_ptr_d [NUM_CHANNELS];
    ptr_t       rd_ptr_q [NUM_CHANNELS];
    ptr_t       rd_ptr_d [NUM_CHANNELS];
    cnt_t       count_q  [NUM_CHANNELS];
    cnt_t       count_d  [NUM_CHANNELS];
    logic       ack_q, ack_d;
    arb_state_e state_q, state_d;
    data_t      out_data_q, out_data_d;
    ch_t        out_ch_q, out_ch_d;
    ch_t        last_q, last_d;

    logic [NUM_CHANNELS-1:0] push_vec, pop_vec;
    logic target_full, wr_take, wr_store, pop;
    logic found;
    ch_t  cand, pick;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            is_empty_out[c]       = (count_q[c] == '0);
            is_full_out[c]        = (count_q[c] == FULL_CNT);
            is_almost_full_out[c] = (count_q[c] >= AF_CNT);
        end
    end

    assign target_full = is_full_out[bus.request_channel_in];
    assign pop         = bus.issue_ack_in && (state_q == PRESENT);

`ifdef MC_FIFO_OVERFLOW_DROP_EN
    logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;

    assign wr_take  = bus.request_valid_in && !ack_q;
    assign wr_store = wr_take && !target_full;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_take && target_full) ovf_d[bus.request_channel_in] = 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) ovf_q <= '0;
        else          ovf_q <= ovf_d;
    end

    assign overflow_out = ovf_q;
`else
    assign wr_take      = bus.request_valid_in && !ack_q && !target_full;
    assign wr_store     = wr_take;
    assign overflow_out = '0;
`endif

    assign ack_d = wr_take;

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            push_vec[c] = wr_store && (bus.request_channel_in == ch_t'(c));
            pop_vec[c]  = pop && (out_ch_q == ch_t'(c));
            wr_ptr_d[c] = wr_ptr_q[c] + ptr_t'(push_vec[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + ptr_t'(pop_vec[c]);
            count_d[c]  = count_q[c] + cnt_t'(push_vec[c])
                        - cnt_t'(pop_vec[c]);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // Storage is not reset: contents are unreachable once counts clear.
    always_ff @(posedge clk_in) begin
        if (wr_store) begin
            mem_q[bus.request_channel_in][wr_ptr_q[bus.request_channel_in]]
                <= bus.request_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        last_d     = last_q;
        found      = 1'b0;
        cand       = '0;
        pick       = '0;
        unique case (state_q)
            IDLE: begin
                for (int i = 1; i <= NUM_CHANNELS; i++) begin
                    cand = last_q + ch_t'(i);
                    if (!found && !is_empty_out[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end
                end
                if (found) begin
                    state_d    = PRESENT;
                    out_ch_d   = pick;
                    out_data_d = mem_q[pick][rd_ptr_q[pick]];
                end
            end
            PRESENT: begin
                if (pop) begin
                    state_d = IDLE;
                    last_d  = out_ch_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            out_data_q <= '0;
            out_ch_q   <= '0;
            last_q     <= ch_t'(NUM_CHANNELS - 1);
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            last_q     <= last_d;
            ack_q      <= ack_d;
        end
    end

    assign bus.issue_ack_out       = ack_q;
    assign bus.request_out         = out_data_q;
    assign bus.request_channel_out = out_ch_q;
    assign bus.request_valid_out   = (state_q == PRESENT);
endmodule

// File: tb/tb_multi_channel_fifo_queue.sv
// Bench for multi_channel_fifo_queue: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_multi_channel_fifo_queue;
    localparam int NCH = 4;
    localparam int QS  = 16;
    localparam int AFT = 12;
`ifdef MC_FIFO_OVERFLOW_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    always #5 clk_in = ~clk_in;

    multi_channel_fifo_queue_if #(
        .CHANNEL_ID_WIDTH(2),
        .SINGLE_ENTRY_WIDTH_IN_BITS(64)
    ) bus ();

    logic [NCH-1:0] is_empty_out, is_full_out, is_almost_full_out, overflow_out;

    multi_channel_fifo_queue dut (
        .clk_in             (clk_in),
        .reset_in           (reset_in),
        .bus                (bus),
        .is_empty_out       (is_empty_out),
        .is_full_out        (is_full_out),
        .is_almost_full_out (is_almost_full_out),
        .overflow_out       (overflow_out)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: one queue per channel plus the presented entry.
    logic [63:0] mq [NCH][$];
    logic        m_ack, m_valid;
    logic [63:0] m_data;
    int          m_ch, m_last;
    logic [3:0]  m_ovf;

    always @(posedge clk_in or posedge reset_in) begin
        int wch, c;
        bit room, take, pop_now, found;
        if (reset_in) begin
            for (int k = 0; k < NCH; k++) mq[k].delete();
            m_ack = 0; m_valid = 0; m_data = '0;
            m_ch = 0; m_last = NCH - 1; m_ovf = '0;
        end else begin
            wch     = int'(bus.request_channel_in);
            room    = (mq[wch].size() < QS);
            take    = bus.request_valid_in && !m_ack && (room || DROP);
            pop_now = bus.issue_ack_in && m_valid;
            if (m_valid) begin
                if (pop_now) begin
                    void'(mq[m_ch].pop_front());
                    m_valid = 0;
                    m_last  = m_ch;
                end
            end else begin
                found = 0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last + k) % NCH;
                    if (!found && mq[c].size() > 0) begin
                        found = 1; m_valid = 1; m_ch = c; m_data = mq[c][0];
                    end
                end
            end
            if (take) begin
                if (room) mq[wch].push_back(bus.request_in);
                else      m_ovf[wch] = 1'b1;
            end
            m_ack = take;
        end
    end

    always @(negedge clk_in) begin
        logic [3:0] e_emp, e_full, e_af;
        if (chk_en) begin
            for (int k = 0; k < NCH; k++) begin
                e_emp[k]  = (mq[k].size() == 0);
                e_full[k] = (mq[k].size() == QS);
                e_af[k]   = (mq[k].size() >= AFT);
            end
            check("ack", 64'(bus.issue_ack_out), 64'(m_ack));
            check("valid", 64'(bus.request_valid_out), 64'(m_valid));
            if (m_valid) begin
                check("data", bus.request_out, m_data);
                check("chan", 64'(bus.request_channel_out), 64'(m_ch));
            end
            check("empty", 64'(is_empty_out), 64'(e_emp));
            check("full", 64'(is_full_out), 64'(e_full));
            check("afull", 64'(is_almost_full_out), 64'(e_af));
            check("ovf", 64'(overflow_out), 64'(m_ovf));
        end
    end

    task automatic push(input int ch, input logic [63:0] d, output bit acked);
        acked = 0;
        bus.request_valid_in   = 1'b1;
        bus.request_channel_in = 2'(ch);
        bus.request_in         = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (bus.issue_ack_out) begin acked = 1; break; end
        end
        if (!acked) begin
            total++; bad++;
            $display("FAIL push_timeout: got no ack want ack ch=%0d", ch);
        end
        bus.request_valid_in = 1'b0;
    endtask

    task automatic pop(output logic [63:0] d, output logic [1:0] ch);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.request_valid_out) begin ok = 1; break; end
            @(negedge clk_in);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL pop_timeout: got valid=0 want valid=1");
        end
        d  = bus.request_out;
        ch = bus.request_channel_out;
        bus.issue_ack_in = ok;
        @(negedge clk_in);
        bus.issue_ack_in = 1'b0;
    endtask

    int rr_ch [3] = '{0, 2, 3};

    initial begin
        logic [63:0] d;
        logic [1:0]  ch;
        bit          ok;
        int          acks, pct;
        bus.request_in = '0; bus.request_channel_in = '0;
        bus.request_valid_in = 1'b0; bus.issue_ack_in = 1'b0;

        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        chk_en   = 1'b1;
        check("rst_ack", 64'(bus.issue_ack_out), 64'd0);
        check("rst_valid", 64'(bus.request_valid_out), 64'd0);
        check("rst_data", bus.request_out, 64'd0);
        check("rst_chan", 64'(bus.request_channel_out), 64'd0);
        check("rst_empty", 64'(is_empty_out), 64'hF);
        check("rst_full", 64'(is_full_out | is_almost_full_out), 64'd0);
        check("rst_ovf", 64'(overflow_out), 64'd0);

        for (int i = 0; i < 8; i++) push(0, 64'hFFFF_FFFF_FFFF_FFFF - 64'(i), ok);
        for (int i = 0; i < 8; i++) begin
            pop(d, ch);
            check("t1_data", d, 64'hFFFF_FFFF_FFFF_FFFF - 64'(i));
            check("t1_chan", 64'(ch), 64'd0);
        end
        @(negedge clk_in);
        check("t1_empty0", 64'(is_empty_out[0]), 64'd1);

        for (int i = 0; i < 16; i++) begin
            push(1, 64'h100 + 64'(i), ok);
            check("t2_afull1", 64'(is_almost_full_out[1]), 64'(i >= 11));
        end
        check("t2_full1", 64'(is_full_out[1]), 64'd1);
        if (!DROP) begin
            @(negedge clk_in);
            bus.request_valid_in = 1'b1;
            bus.request_channel_in = 2'd1;
            bus.request_in = 64'h110;
            repeat (6) begin
                @(negedge clk_in);
                check("t2_stall_ack", 64'(bus.issue_ack_out), 64'd0);
            end
            pop(d, ch);
            check("t2_first", d, 64'h100);
            ok = 0;
            for (int n = 0; n < 10 && !ok; n++) begin
                if (bus.issue_ack_out) ok = 1;
                else @(negedge clk_in);
            end
            check("t2_late_ack", 64'(ok), 64'd1);
            bus.request_valid_in = 1'b0;
            check("t2_refull", 64'(is_full_out[1]), 64'd1);
            for (int i = 1; i <= 16; i++) begin
                pop(d, ch);
                check("t2_drain", d, 64'h100 + 64'(i));
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                pop(d, ch);
                check("t2_drain", d, 64'h100 + 64'(i));
            end
        end

        for (int k = 0; k < 3; k++) begin
            push(rr_ch[k], 64'h10 * 64'(rr_ch[k]) + 64'h10, ok);
            push(rr_ch[k], 64'h10 * 64'(rr_ch[k]) + 64'h11, ok);
        end
        for (int i = 0; i < 6; i++) begin
            pop(d, ch);
            check("rr_chan", 64'(ch), 64'(rr_ch[i % 3]));
            check("rr_data", d, 64'h10 * 64'(rr_ch[i % 3]) + 64'h10 + 64'(i / 3));
        end

        for (int i = 0; i < 40; i++) begin
            push(2, 64'hA000 + 64'(i), ok);
            pop(d, ch);
            check("wrap_data", d, 64'hA000 + 64'(i));
            check("wrap_chan", 64'(ch), 64'd2);
        end

        for (int i = 0; i < 5; i++) push(0, 64'hB0 + 64'(i), ok);
        @(negedge clk_in);
        for (int k = 0; k < 3; k++) begin
            check("sim_head", bus.request_out, 64'hB0 + 64'(k));
            bus.issue_ack_in = 1'b1;
            bus.request_valid_in = 1'b1;
            bus.request_channel_in = 2'd0;
            bus.request_in = 64'hB5 + 64'(k);
            @(negedge clk_in);
            check("sim_ack", 64'(bus.issue_ack_out), 64'd1);
            bus.issue_ack_in = 1'b0;
            bus.request_valid_in = 1'b0;
            @(negedge clk_in);
        end
        for (int i = 3; i < 8; i++) begin
            pop(d, ch);
            check("sim_drain", d, 64'hB0 + 64'(i));
        end
        @(negedge clk_in);
        check("sim_empty", 64'(is_empty_out), 64'hF);

        push(1, 64'hC0, ok);
        push(3, 64'hC1, ok);
        bus.request_valid_in = 1'b1;
        bus.request_in = 64'hC2;
        @(negedge clk_in);
        #2 reset_in = 1'b1;
        #1;
        check("mrst_valid", 64'(bus.request_valid_out), 64'd0);
        check("mrst_ack", 64'(bus.issue_ack_out), 64'd0);
        check("mrst_data", bus.request_out, 64'd0);
        check("mrst_chan", 64'(bus.request_channel_out), 64'd0);
        check("mrst_empty", 64'(is_empty_out), 64'hF);
        check("mrst_flags", 64'({is_full_out, is_almost_full_out, overflow_out}), 64'd0);
        bus.request_valid_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;

        if (DROP) begin
            acks = 0;
            for (int i = 0; i < 18; i++) begin
                push(3, 64'hD0 + 64'(i), ok);
                acks += int'(ok);
            end
            check("drop_acks", 64'(acks), 64'd18);
            check("drop_ovf", 64'(overflow_out), 64'h8);
            for (int i = 0; i < 16; i++) begin
                pop(d, ch);
                check("drop_data", d, 64'hD0 + 64'(i));
            end
            @(negedge clk_in);
            check("drop_valid", 64'(bus.request_valid_out), 64'd0);
            check("drop_empty", 64'(is_empty_out), 64'hF);
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            pct = (cyc < 2000) ? 20 : 70;
            if (!bus.request_valid_in || bus.issue_ack_out) begin
                bus.request_valid_in   = ($urandom_range(99) < 75);
                bus.request_channel_in = 2'($urandom_range(3));
                bus.request_in         = {$urandom, $urandom};
            end
            bus.issue_ack_in = ($urandom_range(99) < pct);
            @(negedge clk_in);
        end
        bus.request_valid_in = 1'b0;
        bus.issue_ack_in     = 1'b1;
        repeat (200) @(negedge clk_in);
        bus.issue_ack_in = 1'b0;
        @(negedge clk_in);
        check("final_empty", 64'(is_empty_out), 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
